// File: rtl/pcpu_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module : pcpu_mem_pkg
// Brief  : Size encodings, FSM state type, byte-enable constants and lane
//          helpers shared by the memory access unit.
// Rev    : 1.0  initial release
// ============================================================================
package pcpu_mem_pkg;

    localparam logic [1:0] c_SIZE_BYTE     = 2'b00;
    localparam logic [1:0] c_SIZE_HALF     = 2'b01;
    localparam logic [1:0] c_SIZE_WORD     = 2'b10;
    localparam logic [1:0] c_SIZE_WORD_ALT = 2'b11;

    localparam logic [3:0] c_BE_BYTE    = 4'b0001;
    localparam logic [3:0] c_BE_HALF_LO = 4'b0011;
    localparam logic [3:0] c_BE_HALF_HI = 4'b1100;
    localparam logic [3:0] c_BE_WORD    = 4'b1111;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mem_state_t;

    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
        logic ok;
        case (size)
            c_SIZE_BYTE: ok = 1'b1;
            c_SIZE_HALF: ok = ~off[0];
            default:     ok = (off == 2'b00);
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            c_SIZE_BYTE: be = c_BE_BYTE << off;
            c_SIZE_HALF: be = off[1] ? c_BE_HALF_HI : c_BE_HALF_LO;
            default:     be = c_BE_WORD;
        endcase
        return be;
    endfunction

    // Replicate narrow store data so it lands in whichever lane dm_be selects.
    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] lanes;
        case (size)
            c_SIZE_BYTE: lanes = {4{data[7:0]}};
            c_SIZE_HALF: lanes = {2{data[15:0]}};
            default:     lanes = data;
        endcase
        return lanes;
    endfunction

endpackage : pcpu_mem_pkg
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// ============================================================================
// Module : load_extend
// Brief  : Selects the addressed lane of a read word and sign/zero extends it.
// Rev    : 1.0  initial release
// ============================================================================
module load_extend
    import pcpu_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        ld_unsigned,
    output logic [31:0] result
);

    logic [31:0] w_lane;
    logic        w_byte_sign;
    logic        w_half_sign;

    assign w_lane      = rdata >> {offset, 3'b000};
    assign w_byte_sign = ~ld_unsigned & w_lane[7];
    assign w_half_sign = ~ld_unsigned & w_lane[15];

    always_comb begin
        result = rdata;
        case (size)
            c_SIZE_BYTE: result = {{24{w_byte_sign}}, w_lane[7:0]};
            c_SIZE_HALF: result = {{16{w_half_sign}}, w_lane[15:0]};
            default:     result = rdata;
        endcase
    end

endmodule : load_extend
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module : mem_access_unit
// Brief  : MEM-stage load/store sequencer: issues one data-bus transaction per
//          op, stalls the pipeline until ack, and aborts on a watchdog timeout.
// Rev    : 1.0  initial release
// ============================================================================
module mem_access_unit
    import pcpu_mem_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        flush,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [1:0]  ex_mem_size,
    input  logic        ex_mem_unsigned,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_be,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic [31:0] mem_rddata,
    output logic        stall_out,
    output logic        misalign_exc,
    output logic        bus_err
);

    localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT);

    mem_state_t  r_state;
    mem_state_t  w_state_next;
    logic        r_dm_req;
    logic        r_dm_we;
    logic [31:0] r_dm_addr;
    logic [31:0] r_dm_wdata;
    logic [3:0]  r_dm_be;
    logic [1:0]  r_off;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [7:0]  r_wd;

    logic        w_memop;
    logic        w_aligned;
    logic        w_issue;
    logic        w_busy;
    logic        w_done;
    logic        w_timeout;
    logic [31:0] w_ld_result;

    assign w_memop   = ex_valid & (ex_mem_read | ex_mem_write) & ~flush;
    assign w_aligned = is_aligned(ex_mem_size, ex_addr[1:0]);
    assign w_busy    = (r_state == ST_BUSY);
    assign w_issue   = (r_state == ST_IDLE) & w_memop & w_aligned;
    assign w_done    = w_busy & dm_ack;
    // The abort fires in the BUSY cycle whose count would reach TIMEOUT; ack wins.
    assign w_timeout = w_busy & ~dm_ack & ((r_wd + 8'd1) == c_TIMEOUT);

    load_extend u_load_extend (
        .rdata       (dm_rdata),
        .offset      (r_off),
        .size        (r_size),
        .ld_unsigned (r_unsigned),
        .result      (w_ld_result)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Outputs are gated by Rst so nothing leaks out while reset is held.
    always_comb begin
        w_state_next = r_state;
        stall_out    = 1'b0;
        misalign_exc = 1'b0;
        bus_err      = 1'b0;
        mem_rddata   = 32'h0;
        case (r_state)
            ST_IDLE: begin
                if (w_memop) begin
                    if (w_aligned) begin
                        w_state_next = ST_BUSY;
                        stall_out    = ~Rst;
                    end else begin
                        misalign_exc = ~Rst;
                    end
                end
            end
            ST_BUSY: begin
                if (w_done) begin
                    w_state_next = ST_IDLE;
                    if (!r_dm_we && !Rst) begin
                        mem_rddata = w_ld_result;
                    end
                end else if (w_timeout) begin
                    w_state_next = ST_IDLE;
                    bus_err      = ~Rst;
                end else begin
                    stall_out = ~Rst;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_dm_req   <= 1'b0;
            r_dm_we    <= 1'b0;
            r_dm_addr  <= 32'h0;
            r_dm_wdata <= 32'h0;
            r_dm_be    <= 4'h0;
            r_off      <= 2'b00;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_wd       <= 8'h0;
        end else if (w_issue) begin
            r_dm_req   <= 1'b1;
            r_dm_we    <= ex_mem_write;
            r_dm_addr  <= {ex_addr[31:2], 2'b00};
            r_dm_wdata <= store_lanes(ex_mem_size, ex_wdata);
            r_dm_be    <= byte_enables(ex_mem_size, ex_addr[1:0]);
            r_off      <= ex_addr[1:0];
            r_size     <= ex_mem_size;
            r_unsigned <= ex_mem_unsigned;
            r_wd       <= 8'h0;
        end else if (w_busy) begin
            if (w_done || w_timeout) begin
                r_dm_req <= 1'b0;
            end else begin
                r_wd <= r_wd + 8'd1;
            end
        end
    end

    assign dm_req   = r_dm_req;
    assign dm_we    = r_dm_we;
    assign dm_addr  = r_dm_addr;
    assign dm_wdata = r_dm_wdata;
    assign dm_be    = r_dm_be;

endmodule : mem_access_unit
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_access_unit
// Brief  : Scoreboard bench for mem_access_unit with a behavioural bus slave.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mem_access_unit;

    localparam int c_TO = 4;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        flush;
    logic        ex_valid;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [1:0]  ex_mem_size;
    logic        ex_mem_unsigned;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic [31:0] mem_rddata;
    logic        stall_out;
    logic        misalign_exc;
    logic        bus_err;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rd;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    mem_access_unit #(.TIMEOUT(c_TO)) dut (
        .Clk             (Clk),
        .Rst             (Rst),
        .flush           (flush),
        .ex_valid        (ex_valid),
        .ex_mem_read     (ex_mem_read),
        .ex_mem_write    (ex_mem_write),
        .ex_mem_size     (ex_mem_size),
        .ex_mem_unsigned (ex_mem_unsigned),
        .ex_addr         (ex_addr),
        .ex_wdata        (ex_wdata),
        .dm_req          (dm_req),
        .dm_we           (dm_we),
        .dm_addr         (dm_addr),
        .dm_wdata        (dm_wdata),
        .dm_be           (dm_be),
        .dm_ack          (dm_ack),
        .dm_rdata        (dm_rdata),
        .mem_rddata      (mem_rddata),
        .stall_out       (stall_out),
        .misalign_exc    (misalign_exc),
        .bus_err         (bus_err)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic m_aligned(input logic [1:0] sz, input logic [1:0] off);
        if (sz == 2'b00) return 1'b1;
        if (sz == 2'b01) return !off[0];
        return off == 2'b00;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] one;
        one = 4'b0001;
        if (sz == 2'b00) return one << off;
        if (sz == 2'b01) return off[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] w);
        if (sz == 2'b00) return {w[7:0], w[7:0], w[7:0], w[7:0]};
        if (sz == 2'b01) return {w[15:0], w[15:0]};
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [1:0] off,
                                           input logic [1:0] sz, input logic uns);
        logic [31:0] lane;
        lane = rd >> (8 * off);
        if (sz == 2'b00) return uns ? {24'h0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
        if (sz == 2'b01) return uns ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
        return rd;
    endfunction

    task automatic clear_inputs();
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; flush = 1'b0;
        ex_mem_size = 2'b00; ex_mem_unsigned = 1'b0; ex_addr = 32'h0; ex_wdata = 32'h0;
        dm_ack = 1'b0; dm_rdata = 32'h0;
    endtask

    // One op: issue cycle, then BUSY cycles until the slave acks after
    // ack_delay non-ack cycles or the watchdog aborts.
    task automatic do_op(input string name, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                         input int ack_delay, input logic flush_busy);
        exp_t e;
        exp_t cur;
        logic al;
        logic ack;
        logic to;
        logic done;
        al = m_aligned(sz, addr[1:0]);
        tick();
        ex_valid = 1'b1; ex_mem_read = !wr; ex_mem_write = wr; ex_mem_size = sz;
        ex_mem_unsigned = uns; ex_addr = addr; ex_wdata = wdata; flush = 1'b0; dm_ack = 1'b0;
        #4;
        check({name, ".issue_stall"}, 32'(stall_out), 32'(al));
        check({name, ".issue_misalign"}, 32'(misalign_exc), 32'(!al));
        check({name, ".issue_req"}, 32'(dm_req), 32'h0);
        if (al) begin
            e.we = wr; e.addr = {addr[31:2], 2'b00}; e.wdata = m_wdata(sz, wdata);
            e.be = m_be(sz, addr[1:0]); e.rd = wr ? 32'h0 : m_load(rdata, addr[1:0], sz, uns);
            sb_q.push_back(e);
        end
        tick();
        clear_inputs();
        if (!al) begin
            #4;
            check({name, ".no_req"}, 32'(dm_req), 32'h0);
            check({name, ".misalign_pulse_end"}, 32'(misalign_exc), 32'h0);
            return;
        end
        if (flush_busy) begin
            ex_valid = 1'b1; ex_mem_read = !wr; ex_mem_write = wr; ex_addr = addr; flush = 1'b1;
        end
        done = 1'b0;
        cur  = e;
        for (int i = 0; i < 20 && !done; i++) begin
            if (i > 0) tick();
            ack = (i == ack_delay);
            dm_ack = ack; dm_rdata = rdata;
            #4;
            if (i == 0) begin
                if (sb_q.size() == 0) begin
                    check({name, ".sb_empty"}, 32'h0, 32'h1);
                end else begin
                    cur = sb_q.pop_front();
                    check({name, ".dm_we"}, 32'(dm_we), 32'(cur.we));
                    check({name, ".dm_wdata"}, dm_wdata, cur.wdata);
                end
            end
            check({name, ".dm_req_held"}, 32'(dm_req), 32'h1);
            check({name, ".dm_addr"}, dm_addr, cur.addr);
            check({name, ".dm_be"}, 32'(dm_be), 32'(cur.be));
            to = !ack && (i + 1 == c_TO);
            check({name, ".busy_stall"}, 32'(stall_out), 32'(!ack && !to));
            check({name, ".bus_err"}, 32'(bus_err), 32'(to));
            check({name, ".mem_rddata"}, mem_rddata, (ack && !wr) ? cur.rd : 32'h0);
            done = ack || to;
        end
        if (!done) check({name, ".op_bound"}, 32'h0, 32'h1);
        tick();
        clear_inputs();
        #4;
        check({name, ".after_req"}, 32'(dm_req), 32'h0);
        check({name, ".after_stall"}, 32'(stall_out), 32'h0);
        check({name, ".after_bus_err"}, 32'(bus_err), 32'h0);
        check({name, ".after_rddata"}, mem_rddata, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        Rst = 1'b1;
        clear_inputs();
        #2;
        // Misaligned op presented while in reset: nothing may escape.
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_size = 2'b10; ex_addr = 32'h1;
        #1;
        check("rst.dm_req", 32'(dm_req), 32'h0);
        check("rst.dm_addr", dm_addr, 32'h0);
        check("rst.dm_be", 32'(dm_be), 32'h0);
        check("rst.stall", 32'(stall_out), 32'h0);
        check("rst.misalign", 32'(misalign_exc), 32'h0);
        check("rst.rddata", mem_rddata, 32'h0);
        clear_inputs();
        tick();
        tick();
        Rst = 1'b0;

        do_op("lb_0x103",   1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0,          32'h80FF_FF12, 0,  1'b0);
        do_op("sh_0x202",   1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 32'h0,          1,  1'b0);
        do_op("lw_0x105",   1'b0, 2'b10, 1'b0, 32'h0000_0105, 32'h0,          32'h0,          0,  1'b0);
        do_op("lhu_to",     1'b0, 2'b01, 1'b1, 32'h0000_0300, 32'h0,          32'h1234_5678, 99, 1'b0);
        do_op("lw_flush",   1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0,          32'hDEAD_BEEF, 2,  1'b1);
        do_op("lbu_0x101",  1'b0, 2'b00, 1'b1, 32'h0000_0101, 32'h0,          32'h0000_8000, 1,  1'b0);
        do_op("lh_0x402",   1'b0, 2'b01, 1'b0, 32'h0000_0402, 32'h0,          32'h8001_0000, 0,  1'b0);
        do_op("sb_0x007",   1'b1, 2'b00, 1'b0, 32'h0000_0007, 32'h0000_005A, 32'h0,          0,  1'b0);
        do_op("lw11_ackto", 1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0,          32'h1234_5678, 3,  1'b0);
        do_op("lh_0x201",   1'b0, 2'b01, 1'b0, 32'h0000_0201, 32'h0,          32'h0,          0,  1'b0);

        // Flushed op in IDLE: neither issues nor faults.
        tick();
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_size = 2'b10; ex_addr = 32'h41; flush = 1'b1;
        #4;
        check("idle_flush.stall", 32'(stall_out), 32'h0);
        check("idle_flush.misalign", 32'(misalign_exc), 32'h0);
        tick();
        clear_inputs();
        dm_ack = 1'b1; dm_rdata = 32'hFFFF_FFFF;
        #4;
        check("idle_flush.req", 32'(dm_req), 32'h0);
        check("idle_ack.rddata", mem_rddata, 32'h0);
        check("idle_ack.bus_err", 32'(bus_err), 32'h0);
        tick();
        clear_inputs();
        #4;
        check("idle_ack.req", 32'(dm_req), 32'h0);

        // Reset mid-BUSY abandons the transaction asynchronously.
        tick();
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_size = 2'b10; ex_addr = 32'h600;
        tick();
        clear_inputs();
        #4;
        check("rst_busy.pre_req", 32'(dm_req), 32'h1);
        Rst = 1'b1;
        #1;
        check("rst_busy.req", 32'(dm_req), 32'h0);
        check("rst_busy.addr", dm_addr, 32'h0);
        check("rst_busy.stall", 32'(stall_out), 32'h0);
        check("rst_busy.bus_err", 32'(bus_err), 32'h0);
        tick();
        Rst = 1'b0;
        do_op("lw_post_rst", 1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'h0, 32'hCAFE_F00D, 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mem_access_unit
`default_nettype wire

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT, default 255, maximum BUSY cycles before abort (1..255).
REQ-002 One clock and one reset: Clk input 1, rising-edge clock; Rst input 1, asynchronous active-high reset.
REQ-003 flush  input 1  squashes an op not yet issued to the bus.
REQ-004 ex_valid  input 1  EX_MEM slot holds a valid instruction.
REQ-005 ex_mem_read / ex_mem_write  input 1 each  load / store (never both).
REQ-006 ex_mem_size  input 2  00 byte, 01 half, 10 word; 11 treated as word.
REQ-007 ex_mem_unsigned  input 1  zero-extend loads when 1, else sign-extend.
REQ-008 ex_addr  input 32  byte address; ex_wdata  input 32  store data (low-aligned).
REQ-009 dm_req  output 1; dm_we  output 1; dm_addr  output 32 (word aligned); dm_wdata  output 32; dm_be  output 4.
REQ-010 dm_ack  input 1  transaction complete; dm_rdata  input 32  read word, valid with dm_ack.
REQ-011 mem_rddata  output 32  extended load data to MEM_WB rddata input.
REQ-012 stall_out  output 1  freezes PC, IF_ID, ID_EX, EX_MEM.
REQ-013 misalign_exc / bus_err  output 1 each  one-cycle fault pulses.

Function
REQ-014 States: IDLE, BUSY; memop = ex_valid & (read|write) & ~flush.
REQ-015 Aligned: byte always; half needs addr[0]=0; word needs addr[1:0]=00.
REQ-016 IDLE & memop & aligned: register dm_addr={addr[31:2],00}, dm_we, dm_be, dm_wdata, latched offset/size/unsigned; next state BUSY with dm_req=1.
REQ-017 IDLE & memop & misaligned: no request, misalign_exc=1 that cycle, stall_out=0.
REQ-018 stall_out = (IDLE & memop & aligned) | (BUSY & ~dm_ack), combinational.
REQ-019 BUSY: dm_req and all dm_* outputs held stable until dm_ack.
REQ-020 BUSY & dm_ack: mem_rddata valid combinationally that cycle, stall_out=0, next state IDLE, dm_req=0 next cycle; minimum op latency 2 cycles (1 stall cycle).
REQ-021 mem_rddata = 0 in every cycle except BUSY & dm_ack & ~dm_we.
REQ-022 Byte enables: byte 0001<<off; half off[1]?1100:0011; word 1111.
REQ-023 Store data: byte replicated x4; half replicated x2; word unchanged.
REQ-024 Load: lane = dm_rdata >> 8*off; byte/half sign- or zero-extended to 32 per latched unsigned.
REQ-025 8-bit watchdog counts BUSY cycles without dm_ack; cleared on entry to BUSY.
REQ-026 Count reaching TIMEOUT: bus_err=1 one cycle, dm_req drops, state IDLE, stall_out=0, mem_rddata=0.
REQ-027 dm_ack and timeout in same cycle: dm_ack wins, no bus_err.
REQ-028 flush in BUSY is ignored: transaction completes; flush applies only to IDLE issue.
REQ-029 dm_ack in IDLE is ignored.

Reset
REQ-030 Rst asserted: state IDLE, dm_req=0, dm_we=0, dm_addr=0, dm_wdata=0, dm_be=0, watchdog=0, latched fields=0, immediately regardless of Clk.
REQ-031 Rst mid-BUSY abandons the transaction; no bus_err, no misalign_exc.
REQ-032 During reset stall_out=0, mem_rddata=0, fault pulses 0.

Structure
REQ-033 Package pcpu_mem_pkg holds size encodings, state enum, byte-enable constants.
REQ-034 Sub-module load_extend (combinational: rdata, offset, size, unsigned -> 32-bit result).
REQ-035 FSM, watchdog and request registers live in mem_access_unit.

Verification
REQ-036 LB addr 0x103, rdata 0x80FF_FF12, ack 1 cycle later -> dm_be=1000 unused for read, mem_rddata=0xFFFF_FF80, one stall cycle.
REQ-037 SH addr 0x202, wdata 0x0000_ABCD -> dm_addr=0x200, dm_be=1100, dm_wdata=0xABCD_ABCD, dm_we=1.
REQ-038 LW addr 0x105 -> misalign_exc pulse, dm_req never 1, stall_out=0.
REQ-039 LHU addr 0x300, ack withheld, TIMEOUT=4 -> stall 4 cycles then bus_err pulse, IDLE, mem_rddata=0.
REQ-040 LW issued, flush in BUSY, ack 3 cycles later -> transaction completes, mem_rddata=dm_rdata.
REQ-041 Rst pulse in BUSY -> dm_req=0 same cycle, next op issues normally.
